truth_table_sweeper: RTL

Sequential stimulus-and-capture stage that sits directly upstream of a 4-input combinational lab function (inputs A, B, C, D; output f). It replaces a hand-written exhaustive testbench sequence. On `start` it walks all 16 input combinations in binary order, holds each for a programmable number of clocks, and samples f into a 16-bit truth-table word. It then compares that word against an expected table and reports pass/fail, mismatch count and first failing vector.

---
 rtl/truth_table_pkg.sv | 21 ++
 rtl/truth_table_sweeper_hold_timer.sv | 36 +++
 rtl/truth_table_sweeper.sv | 115 +++++++++++
 3 files changed

// File: rtl/truth_table_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_pkg
// Shared definitions for the truth-table sweeper:
//   state_t      - sweeper control states (IDLE, RUN, DONE)
//   NUM_VECTORS  - number of input combinations of the 4-input function
//   IDX_W        - width of the vector index {A,B,C,D}
//   CNT_W        - width of the mismatch counter (must hold 0..16)
// ---------------------------------------------------------------------------
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 5;

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
// Counts the clocks a vector has been driven. Counts 0..HOLD_CYCLES-1 while
// enabled and wraps back to 0 after the final hold cycle.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset
//   clr   in  synchronous clear (new sweep accepted)
//   en    in  count enable (sweep in progress)
//   last  out high while the count is on the final hold cycle
// ---------------------------------------------------------------------------
module hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [7:0] cnt;

    assign last = (cnt == 8'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
// Drives all 16 input combinations of a 4-input combinational function in
// binary order, holds each for HOLD_CYCLES clocks, captures f into a truth
// table and compares it against a golden table latched at start.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            begin a sweep (honoured in IDLE or DONE only)
//   expected[15:0]   golden table, bit i = required f for vector i
//   f                output of the function under test
//   A, B, C, D       current vector, {A,B,C,D} = index (A = MSB)
//   busy             sweep in progress
//   done             sweep finished, held until restart or reset
//   pass             done and no mismatches
//   table_out[15:0]  captured table, bit i = f sampled for vector i
//   mismatch_count   number of differing bits (0..16)
//   first_fail       lowest failing vector index (0 when passing)
// ---------------------------------------------------------------------------
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] expected,
    input  logic                   f,
    output logic                   A,
    output logic                   B,
    output logic                   C,
    output logic                   D,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_VECTORS-1:0] table_out,
    output logic [CNT_W-1:0]       mismatch_count,
    output logic [IDX_W-1:0]       first_fail
);

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       idx;
    logic [NUM_VECTORS-1:0] expected_lat;
    logic                   accept;
    logic                   running;
    logic                   last;
    logic                   sample;

    assign running = (state == RUN);
    assign accept  = start && ((state == IDLE) || (state == DONE));
    // f is captured on the edge that ends the final hold cycle of a vector
    assign sample  = running && last;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (running),
        .last (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (sample && (idx == IDX_W'(NUM_VECTORS - 1))) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx            <= '0;
            expected_lat   <= '0;
            table_out      <= '0;
            mismatch_count <= '0;
            first_fail     <= '0;
        end else if (accept) begin
            idx            <= '0;
            expected_lat   <= expected;
            table_out      <= '0;
            mismatch_count <= '0;
            first_fail     <= '0;
        end else if (sample) begin
            table_out[idx] <= f;
            if (f != expected_lat[idx]) begin
                mismatch_count <= mismatch_count + CNT_W'(1);
                // count still zero means this is the first miss of the sweep
                if (mismatch_count == '0) begin
                    first_fail <= idx;
                end
            end
            // natural 4-bit wrap returns the drive to 0000 after vector 15
            idx <= idx + IDX_W'(1);
        end
    end

    assign {A, B, C, D} = idx;
    assign busy         = running;
    assign done         = (state == DONE);
    assign pass         = done && (mismatch_count == '0);

endmodule
